// File: rtl/nonrestoring_divider.sv
// Sequential 16-bit non-restoring divider: one quotient bit per cycle, 18-cycle latency.
// Define DIVIDER_SIGNED_EN for two's-complement operands; default build is unsigned.
module nonrestoring_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dataQ,
    input  logic [15:0] dataM,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        CORR = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [16:0] a_q, a_d;
    logic [15:0] q_q, q_d;
    logic [16:0] m_q, m_d;
    logic [4:0]  count_q, count_d;
    logic [15:0] dq_q, dq_d;
    logic [15:0] dm_q, dm_d;
    logic        zero_q, zero_d;
    logic [15:0] quot_q, quot_d;
    logic [15:0] rem_q, rem_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    logic [16:0] a_sh_s;
    logic [16:0] a_new_s;
    logic [15:0] a_fix_s;

    // Next-state and datapath update for every FSM state
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        count_d = count_q;
        dq_d    = dq_q;
        dm_d    = dm_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        a_sh_s  = 17'd0;
        a_new_s = 17'd0;
        a_fix_s = 16'd0;

        case (state_q)
            IDLE: begin
                // busy_q is still set during a divide-by-zero done pulse, which blocks start there
                if (start && !busy_q) begin
                    state_d = LOAD;
                    dq_d    = dataQ;
                    dm_d    = dataM;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                a_d     = 17'd0;
                count_d = 5'd16;
                dbz_d   = 1'b0;
                zero_d  = (dm_q == 16'd0);
`ifdef DIVIDER_SIGNED_EN
                q_d = dq_q[15] ? (16'd0 - dq_q) : dq_q;
                m_d = {1'b0, (dm_q[15] ? (16'd0 - dm_q) : dm_q)};
`else
                q_d = dq_q;
                m_d = {1'b0, dm_q};
`endif
                if (dm_q == 16'd0) begin
                    state_d = DONE;
                end else begin
                    state_d = ITER;
                end
            end
            ITER: begin
                a_sh_s = {a_q[15:0], q_q[15]};
                if (a_q[16] == 1'b0) begin
                    a_new_s = a_sh_s - m_q;
                end else begin
                    a_new_s = a_sh_s + m_q;
                end
                a_d     = a_new_s;
                q_d     = {q_q[14:0], ~a_new_s[16]};
                count_d = count_q - 5'd1;
                if (count_q == 5'd1) begin
                    state_d = CORR;
                end else begin
                    state_d = ITER;
                end
            end
            CORR: begin
                a_fix_s = a_q[16] ? (a_q[15:0] + m_q[15:0]) : a_q[15:0];
`ifdef DIVIDER_SIGNED_EN
                quot_d = (dq_q[15] ^ dm_q[15]) ? (16'd0 - q_q) : q_q;
                rem_d  = dq_q[15] ? (16'd0 - a_fix_s) : a_fix_s;
`else
                quot_d = q_q;
                rem_d  = a_fix_s;
`endif
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                // The zero-divisor path spends its extra cycle here so done lands two edges after acceptance
                if (zero_q) begin
                    quot_d = 16'hFFFF;
                    rem_d  = dq_q;
                    dbz_d  = 1'b1;
                    done_d = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE) || done_d;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= 17'd0;
            q_q     <= 16'd0;
            m_q     <= 17'd0;
            count_q <= 5'd0;
            dq_q    <= 16'd0;
            dm_q    <= 16'd0;
            zero_q  <= 1'b0;
            quot_q  <= 16'd0;
            rem_q   <= 16'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            count_q <= count_d;
            dq_q    <= dq_d;
            dm_q    <= dm_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Scoreboard bench for nonrestoring_divider: directed vectors, decoupled done monitor.
module tb_nonrestoring_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dataQ;
    logic [15:0] dataM;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    nonrestoring_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dataQ       (dataQ),
        .dataM       (dataM),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        int          lat;
        time         t_acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   done_cnt  = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result
    always @(negedge clk) begin
        if (done) begin
            chk("done_width", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", {16'd0, quotient}, {16'd0, e.q});
                chk("remainder", {16'd0, remainder}, {16'd0, e.r});
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.z});
                chk("latency", 32'((($time - e.t_acc) - 5) / 10), 32'(e.lat));
                chk("busy_with_done", {31'd0, busy}, 32'd1);
            end
            done_cnt++;
        end
        prev_done = done;
    end

    task automatic issue(input logic [15:0] q, input logic [15:0] m,
                         input logic [15:0] eq, input logic [15:0] er, input logic ez);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        dataQ = q;
        dataM = m;
        @(posedge clk);
        e.q     = eq;
        e.r     = er;
        e.z     = ez;
        e.lat   = (m == 16'd0) ? 2 : 18;
        e.t_acc = $time;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int n;
        n = 0;
        while (done_cnt <= base && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt <= base) begin
            chk("done_timeout", 32'd1, 32'd0);
        end
    endtask

    task automatic run_op(input logic [15:0] q, input logic [15:0] m,
                          input logic [15:0] eq, input logic [15:0] er, input logic ez);
        int base;
        base = done_cnt;
        issue(q, m, eq, er, ez);
        wait_done(base);
        @(posedge clk);
        #1;
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("quotient_hold", {16'd0, quotient}, {16'd0, eq});
        chk("remainder_hold", {16'd0, remainder}, {16'd0, er});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst   = 1'b1;
        start = 1'b0;
        dataQ = 16'd0;
        dataM = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_quotient", {16'd0, quotient}, 32'd0);
        chk("rst_remainder", {16'd0, remainder}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        run_op(16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1);
`ifdef DIVIDER_SIGNED_EN
        run_op(16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0);
        run_op(16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0);
        run_op(16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 1'b0);
        run_op(16'hFF9C, 16'hFFF9, 16'd14, 16'hFFFE, 1'b0);
`else
        run_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0);
        run_op(16'hABCD, 16'h0010, 16'h0ABC, 16'h000D, 1'b0);
        run_op(16'd7, 16'd100, 16'd0, 16'd7, 1'b0);
`endif
        run_op(16'd1000, 16'd1000, 16'd1, 16'd0, 1'b0);

        // Second start while busy must be dropped
        base = done_cnt;
        issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        repeat (4) @(negedge clk);
        chk("busy_mid_op", {31'd0, busy}, 32'd1);
        start = 1'b1;
        dataQ = 16'd50;
        dataM = 16'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(base);
        repeat (25) @(negedge clk);
        chk("single_done", 32'(done_cnt - base), 32'd1);

        // Reset mid-iteration aborts with no done pulse
        base = done_cnt;
        @(negedge clk);
        start = 1'b1;
        dataQ = 16'd500;
        dataM = 16'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_quotient", {16'd0, quotient}, 32'd0);
        chk("abort_remainder", {16'd0, remainder}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - base), 32'd0);

        run_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nonrestoring_divider.md
NONRESTORING_DIVIDER -- requirements
Module: nonrestoring_divider

Interface
REQ-001 Signal list: one clock; reset is synchronous and active-high; clock port clk, reset port rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 dataQ  input  16  dividend; captured on the edge that accepts start.
REQ-006 dataM  input  16  divisor; captured on the edge that accepts start.
REQ-007 quotient  output  16  registered quotient.
REQ-008 remainder  output  16  registered remainder.
REQ-009 busy  output  1  high from the accepting edge until done deasserts.
REQ-010 done  output  1  registered one-cycle completion pulse.
REQ-011 div_by_zero  output  1  registered flag, valid with done.

Function
REQ-012 The FSM SHALL have five states: IDLE, LOAD, ITER, CORR, DONE.
REQ-013 Transitions SHALL be:
- IDLE->LOAD on start=1.
- LOAD->ITER when divisor is nonzero; LOAD->DONE when divisor is zero.
- ITER->CORR when count reaches 0.
- CORR->DONE.
- DONE->IDLE unconditionally.
REQ-014 LOAD SHALL:
- set the 17-bit partial remainder A to 0;
- set Q to the dividend magnitude and M to the divisor magnitude;
- set count to 16.
REQ-015 Each ITER cycle SHALL:
- shift {A,Q} left one bit;
- subtract M from A if the A sign bit was 0, else add M;
- set Q[0] to the inverse of the new A sign bit;
- decrement count.
REQ-016 CORR SHALL add M to A if A is negative, then apply the configured sign rules (REQ-027) to Q and A.
REQ-017 Nominal latency: done SHALL be high in the cycle beginning 18 rising edges after the edge that accepted start.
REQ-018 Divide by zero: done SHALL be high in the cycle beginning 2 edges after acceptance, with:
- quotient=16'hFFFF;
- remainder=dividend;
- div_by_zero=1.
REQ-019 done SHALL be high for exactly one cycle per accepted start.
REQ-020 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-021 start asserted in the same cycle done is high SHALL be ignored; it is accepted only from IDLE.
REQ-022 quotient, remainder and div_by_zero SHALL hold their values from done until the next LOAD.
REQ-023 div_by_zero SHALL be cleared in LOAD.
REQ-024 All arithmetic SHALL be 17-bit internally, and results SHALL be truncated to 16 bits.

Reset
REQ-025 rst=1 SHALL force the following on the next rising edge, regardless of state, including mid-ITER:
- state=IDLE;
- quotient=0, remainder=0;
- busy=0, done=0, div_by_zero=0;
- count=0.
REQ-026 rst SHALL have priority over start, and an operation aborted by rst SHALL produce no done pulse.

Configuration
REQ-027 Macro DIVIDER_SIGNED_EN SHALL select the operand mode:
- Defined: operands are two's complement; magnitudes are taken in LOAD; the quotient is negated when the operand signs differ; the remainder takes the sign of the dividend.
- -32768 / -1 SHALL yield quotient 16'h8000 and remainder 0.
- Undefined: operands are unsigned, with no sign handling, and the CORR stage performs remainder restore only.
REQ-028 Latency and handshake SHALL be identical in both configurations.

Verification
REQ-029 Both modes: dataQ=100, dataM=7, start pulse -> done at edge+18; quotient=14, remainder=2, div_by_zero=0.
REQ-030 Unsigned mode: dataQ=16'hFFFF, dataM=1 -> quotient=16'hFFFF, remainder=0.
REQ-031 Signed mode:
- dataQ=-7, dataM=2 -> quotient=16'hFFFD, remainder=16'hFFFF;
- dataQ=-32768, dataM=-1 -> quotient=16'h8000, remainder=0.
REQ-032 dataM=0, dataQ=1234 -> done at edge+2; quotient=16'hFFFF, remainder=1234, div_by_zero=1.
REQ-033 Start accepted, then a second start at cycle 5 -> exactly one done pulse, with results for the first operands only.
REQ-034 Start accepted, then rst at cycle 8 -> next edge: busy=0, quotient=0, remainder=0; no done pulse; a new start afterwards completes normally.
